// File: rtl/perceptron_train_ctrl_if.sv
// Bundle of the training-request, predictor read-port and weight-table signals
// shared between the perceptron training controller and its surroundings.
interface perceptron_train_ctrl_if #(
  parameter int NUM_PERCEPTRONS = 128,
  parameter int HISTORY_LENGTH  = 32,
  parameter int WEIGHT_WIDTH    = 8
) ();
  localparam int ADDR_WIDTH = $clog2(NUM_PERCEPTRONS);
  localparam int SUM_WIDTH  = WEIGHT_WIDTH + $clog2(HISTORY_LENGTH + 1) + 1;
  localparam int VEC_W      = (HISTORY_LENGTH + 1) * WEIGHT_WIDTH;

  // Training requests from branch resolution
  logic                      trn_valid;
  logic                      trn_ready;
  logic [ADDR_WIDTH-1:0]     trn_idx;
  logic [HISTORY_LENGTH-1:0] trn_hist;
  logic                      trn_taken;
  logic [SUM_WIDTH-1:0]      trn_y;

  // Predictor read-port request
  logic                      pred_req;
  logic [ADDR_WIDTH-1:0]     pred_addr;
  logic                      pred_grant;

  // Weight table ports
  logic [ADDR_WIDTH-1:0]     tbl_raddr;
  logic [VEC_W-1:0]          tbl_rdata;
  logic                      tbl_we;
  logic [ADDR_WIDTH-1:0]     tbl_waddr;
  logic [VEC_W-1:0]          tbl_wdata;

  // Controller side
  modport slave (
    input  trn_valid, trn_idx, trn_hist, trn_taken, trn_y,
    input  pred_req, pred_addr, tbl_rdata,
    output trn_ready, pred_grant, tbl_raddr, tbl_we, tbl_waddr, tbl_wdata
  );

  // Requester / table side
  modport master (
    output trn_valid, trn_idx, trn_hist, trn_taken, trn_y,
    output pred_req, pred_addr, tbl_rdata,
    input  trn_ready, pred_grant, tbl_raddr, tbl_we, tbl_waddr, tbl_wdata
  );
endinterface

// File: rtl/perceptron_train_ctrl.sv
// Perceptron weight-table controller: clears the table after reset, queues
// filtered training requests and read-modify-writes one weight vector per
// request, yielding the shared read port to the predictor whenever it asks.
module perceptron_train_ctrl #(
  parameter int NUM_PERCEPTRONS = 128,
  parameter int HISTORY_LENGTH  = 32,
  parameter int WEIGHT_WIDTH    = 8,
  parameter int ADDR_WIDTH      = $clog2(NUM_PERCEPTRONS),
  parameter int SUM_WIDTH       = WEIGHT_WIDTH + $clog2(HISTORY_LENGTH + 1) + 1,
  parameter int THETA           = 75,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  perceptron_train_ctrl_if.slave bus,
  output logic                   init_done,
  output logic                   busy,
  output logic [31:0]            train_cnt,
  output logic [31:0]            skip_cnt
);
  localparam int NUM_W = HISTORY_LENGTH + 1;
  localparam int VEC_W = NUM_W * WEIGHT_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WEIGHT_WIDTH-1:0] W_MAX = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
  localparam logic [WEIGHT_WIDTH-1:0] W_MIN = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_WRITE} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     idx;
    logic [HISTORY_LENGTH-1:0] hist;
    logic                      taken;
  } req_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  init_done_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [VEC_W-1:0]      wdata_q;

  req_t                  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic                  fifo_empty, fifo_full;
  req_t                  head, incoming;

  logic [SUM_WIDTH:0]    y_ext, y_abs;
  logic                  mispredict, need_train;
  logic                  ready, grant, accept, push, skip, pop;

  // One saturating +/-1 step on a two's-complement weight
  function automatic logic [WEIGHT_WIDTH-1:0] sat_step(input logic [WEIGHT_WIDTH-1:0] w,
                                                       input logic up);
    if (up) return (w == W_MAX) ? w : w + WEIGHT_WIDTH'(1);
    return (w == W_MIN) ? w : w - WEIGHT_WIDTH'(1);
  endfunction

  // Perceptron learning rule over a full packed weight vector
  function automatic logic [VEC_W-1:0] train_vec(input logic [VEC_W-1:0] cur, input req_t r);
    logic [VEC_W-1:0] nxt;
    nxt = cur;
    nxt[0 +: WEIGHT_WIDTH] = sat_step(cur[0 +: WEIGHT_WIDTH], r.taken);
    for (int i = 1; i < NUM_W; i++)
      nxt[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
        sat_step(cur[i*WEIGHT_WIDTH +: WEIGHT_WIDTH], r.hist[i-1] == r.taken);
    return nxt;
  endfunction

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_full  = ((wr_ptr - rd_ptr) == PTR_W'(FIFO_DEPTH));
  assign head       = fifo_mem[rd_ptr[PTR_W-2:0]];
  assign incoming   = '{idx: bus.trn_idx, hist: bus.trn_hist, taken: bus.trn_taken};

  // Training filter: |y| is formed one bit wider so the most-negative y has a magnitude
  assign y_ext      = {bus.trn_y[SUM_WIDTH-1], bus.trn_y};
  assign y_abs      = y_ext[SUM_WIDTH] ? (~y_ext + (SUM_WIDTH+1)'(1)) : y_ext;
  assign mispredict = (!bus.trn_y[SUM_WIDTH-1]) != bus.trn_taken;
  assign need_train = mispredict | (y_abs <= (SUM_WIDTH+1)'(THETA));

  // Handshake and read-port arbitration; the predictor always wins the port
  assign ready  = !rst & init_done_q & !fifo_full;
  assign grant  = !rst & bus.pred_req & init_done_q;
  assign accept = bus.trn_valid & ready;
  assign push   = accept & need_train;
  assign skip   = accept & !need_train;
  assign pop    = (state == S_READ) & !grant;

  assign bus.trn_ready  = ready;
  assign bus.pred_grant = grant;
  assign bus.tbl_raddr  = grant ? bus.pred_addr : head.idx;
  assign bus.tbl_we     = !rst & we_q;
  assign bus.tbl_waddr  = (state == S_INIT) ? sweep_addr : waddr_q;
  assign bus.tbl_wdata  = (state == S_INIT) ? '0 : wdata_q;

  assign init_done = !rst & init_done_q;
  assign busy      = rst | (state != S_IDLE) | !fifo_empty;

  // Request queue storage
  // NOTE: the queue array has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-2:0]] <= incoming;
  end

  // Queue pointers and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      train_cnt <= '0;
      skip_cnt  <= '0;
    end else begin
      if (push)              wr_ptr    <= wr_ptr + PTR_W'(1);
      if (pop)               rd_ptr    <= rd_ptr + PTR_W'(1);
      if (state == S_WRITE)  train_cnt <= train_cnt + 32'd1;
      if (skip)              skip_cnt  <= skip_cnt + 32'd1;
    end
  end

  // Sequencer: clear sweep, then read-modify-write of queued requests
  // NOTE: every register here uses <= so all of them sample pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      sweep_addr  <= '0;
      init_done_q <= 1'b0;
      we_q        <= 1'b1;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        S_INIT: begin
          sweep_addr <= sweep_addr + ADDR_WIDTH'(1);
          if (sweep_addr == ADDR_WIDTH'(NUM_PERCEPTRONS - 1)) begin
            state       <= S_IDLE;
            we_q        <= 1'b0;
            init_done_q <= 1'b1;
          end
        end
        S_IDLE: begin
          if (!fifo_empty) state <= S_READ;
        end
        S_READ: begin
          // The previous WRITE has already committed, so async read data is current.
          if (!grant) begin
            state   <= S_WRITE;
            we_q    <= 1'b1;
            waddr_q <= head.idx;
            wdata_q <= train_vec(bus.tbl_rdata, head);
          end
        end
        S_WRITE: begin
          we_q  <= 1'b0;
          state <= fifo_empty ? S_IDLE : S_READ;
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Self-checking bench for perceptron_train_ctrl: behavioural weight-table
// model, per-write scoreboard, directed scenarios and a randomized phase.
module tb_perceptron_train_ctrl;
  localparam int NUM_P = 128;
  localparam int H     = 32;
  localparam int W     = 8;
  localparam int NUM_W = H + 1;
  localparam int VW    = NUM_W * W;
  localparam int AW    = $clog2(NUM_P);
  localparam int SW    = W + $clog2(H + 1) + 1;
  localparam int THETA = 75;

  typedef struct {
    int            addr;
    logic [VW-1:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done, busy;
  logic [31:0] train_cnt, skip_cnt;

  perceptron_train_ctrl_if #(.NUM_PERCEPTRONS(NUM_P), .HISTORY_LENGTH(H), .WEIGHT_WIDTH(W)) bus ();

  perceptron_train_ctrl #(
    .NUM_PERCEPTRONS(NUM_P), .HISTORY_LENGTH(H), .WEIGHT_WIDTH(W),
    .THETA(THETA), .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .init_done (init_done),
    .busy      (busy),
    .train_cnt (train_cnt),
    .skip_cnt  (skip_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural table: asynchronous read, write at the clock edge
  logic [VW-1:0] tbl_mem [NUM_P];
  assign bus.tbl_rdata = tbl_mem[bus.tbl_raddr];
  always @(posedge clk) if (bus.tbl_we) tbl_mem[bus.tbl_waddr] = bus.tbl_wdata;

  // Reference model state
  int  ref_w [NUM_P][NUM_W];
  wr_t exp_q [$];
  wr_t mon_e;
  int  exp_train, exp_skip;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic logic [VW-1:0] pack(input int idx);
    logic [VW-1:0] v;
    int            w;
    for (int i = 0; i < NUM_W; i++) begin
      w = ref_w[idx][i];
      v[i*W +: W] = w[W-1:0];
    end
    return v;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NUM_P; p++)
      for (int i = 0; i < NUM_W; i++) ref_w[p][i] = 0;
    exp_q.delete();
    exp_train = 0;
    exp_skip  = 0;
  endtask

  task automatic preload(input int idx, input int val);
    for (int i = 0; i < NUM_W; i++) ref_w[idx][i] = val;
    tbl_mem[idx] = pack(idx);
  endtask

  // Perceptron rule applied in plain integer arithmetic
  task automatic model_accept(input int idx, input logic [H-1:0] hist, input logic taken, input int y);
    int  mag;
    bit  mis;
    wr_t e;
    mag = (y < 0) ? -y : y;
    mis = ((y >= 0) != taken);
    if (mis || mag <= THETA) begin
      ref_w[idx][0] = clamp(ref_w[idx][0] + (taken ? 1 : -1));
      for (int k = 0; k < H; k++)
        ref_w[idx][k+1] = clamp(ref_w[idx][k+1] + ((hist[k] == taken) ? 1 : -1));
      e.addr = idx;
      e.data = pack(idx);
      exp_q.push_back(e);
      exp_train++;
    end else begin
      exp_skip++;
    end
  endtask

  // Scoreboard for every training write
  always @(negedge clk) begin
    if (!rst && bus.tbl_we && init_done) begin
      check("write_pending", VW'(exp_q.size() > 0), VW'(1));
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("write_addr", VW'(bus.tbl_waddr), VW'(mon_e.addr));
        check("write_data", bus.tbl_wdata, mon_e.data);
      end
    end
  end

  task automatic send_req(input int idx, input logic [H-1:0] hist, input logic taken,
                          input int y, input bit rand_pred);
    bit done;
    done = 0;
    bus.trn_valid = 1'b1;
    bus.trn_idx   = idx[AW-1:0];
    bus.trn_hist  = hist;
    bus.trn_taken = taken;
    bus.trn_y     = y[SW-1:0];
    for (int n = 0; n < 400 && !done; n++) begin
      if (rand_pred) begin
        bus.pred_req  = ($urandom_range(0, 3) == 0);
        bus.pred_addr = AW'($urandom_range(0, NUM_P - 1));
      end
      #1;
      if (bus.trn_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    check("accept_timeout", VW'(done), VW'(1));
    #1;
    bus.trn_valid = 1'b0;
    if (rand_pred) bus.pred_req = 1'b0;
    if (done) model_accept(idx, hist, taken, y);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int n = 0; n < 2000 && !idle; n++) begin
      @(negedge clk);
      if (!busy) idle = 1;
    end
    check("idle_timeout", VW'(idle), VW'(1));
  endtask

  task automatic reset_and_sweep();
    bus.trn_valid = 1'b0;
    bus.pred_req  = 1'b1;
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    check("rst_init_done", VW'(init_done), VW'(0));
    check("rst_ready", VW'(bus.trn_ready), VW'(0));
    check("rst_grant", VW'(bus.pred_grant), VW'(0));
    check("rst_we", VW'(bus.tbl_we), VW'(0));
    check("rst_busy", VW'(busy), VW'(1));
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < NUM_P; c++) begin
      #1;
      check("sweep_we", VW'(bus.tbl_we), VW'(1));
      check("sweep_addr", VW'(bus.tbl_waddr), VW'(c));
      check("sweep_data", bus.tbl_wdata, '0);
      check("sweep_init_done", VW'(init_done), VW'(0));
      check("sweep_ready", VW'(bus.trn_ready), VW'(0));
      check("sweep_grant", VW'(bus.pred_grant), VW'(0));
      @(negedge clk);
    end
    #1;
    bus.pred_req = 1'b0;
    check("init_done_rise", VW'(init_done), VW'(1));
    check("post_sweep_we", VW'(bus.tbl_we), VW'(0));
    check("post_sweep_busy", VW'(busy), VW'(0));
    check("post_sweep_ready", VW'(bus.trn_ready), VW'(1));
    check("post_sweep_cnts", VW'({train_cnt, skip_cnt}), VW'(0));
    @(negedge clk);
  endtask

  initial begin
    int            y;
    int            idx;
    logic [H-1:0]  hist;
    logic          taken;

    rst = 1'b1;
    bus.trn_valid = 1'b0;
    bus.trn_idx   = '0;
    bus.trn_hist  = '0;
    bus.trn_taken = 1'b0;
    bus.trn_y     = '0;
    bus.pred_req  = 1'b0;
    bus.pred_addr = '0;
    for (int p = 0; p < NUM_P; p++) tbl_mem[p] = {NUM_W{8'hA5}};

    // Reset and clear sweep
    reset_and_sweep();
    check("table_cleared", tbl_mem[77], pack(77));

    // Single request: weights 0 -> +1 with a two-cycle read-modify-write
    send_req(5, '1, 1'b1, 0, 0);
    #1;
    check("q_busy", VW'(busy), VW'(1));
    check("q_we", VW'(bus.tbl_we), VW'(0));
    @(negedge clk); #1;
    check("read_raddr", VW'(bus.tbl_raddr), VW'(5));
    check("read_we", VW'(bus.tbl_we), VW'(0));
    @(negedge clk); #1;
    check("write_we", VW'(bus.tbl_we), VW'(1));
    check("write_waddr", VW'(bus.tbl_waddr), VW'(5));
    check("write_all_plus1", bus.tbl_wdata, {NUM_W{8'h01}});
    @(negedge clk); #1;
    check("train_cnt_1", VW'(train_cnt), VW'(1));
    check("idle_after_1", VW'(busy), VW'(0));
    @(negedge clk);

    // Filter: correct with |y| > THETA is skipped, |y| == THETA trains
    send_req(6, '1, 1'b1, 100, 0);
    wait_idle();
    check("skip_cnt_1", VW'(skip_cnt), VW'(1));
    check("skip_no_train", VW'(train_cnt), VW'(exp_train));
    send_req(6, 32'h0F0F_00FF, 1'b1, 75, 0);
    wait_idle();
    check("theta_trains", VW'(train_cnt), VW'(2));
    check("theta_table", tbl_mem[6], pack(6));

    // Saturation at both ends
    preload(20, 127);
    preload(21, -128);
    send_req(20, '1, 1'b1, 0, 0);
    send_req(21, '1, 1'b0, 0, 0);
    wait_idle();
    check("sat_high", tbl_mem[20], {NUM_W{8'h7F}});
    check("sat_low", tbl_mem[21], {NUM_W{8'h80}});

    // Predictor priority holds the FSM in READ
    send_req(33, 32'hDEAD_BEEF, 1'b1, 0, 0);
    @(negedge clk);
    bus.pred_req  = 1'b1;
    bus.pred_addr = AW'(77);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("arb_grant", VW'(bus.pred_grant), VW'(1));
      check("arb_raddr", VW'(bus.tbl_raddr), VW'(77));
      check("arb_stall_we", VW'(bus.tbl_we), VW'(0));
      @(negedge clk);
    end
    bus.pred_req = 1'b0;
    #1;
    check("arb_release_grant", VW'(bus.pred_grant), VW'(0));
    check("arb_release_raddr", VW'(bus.tbl_raddr), VW'(33));
    @(negedge clk); #1;
    check("arb_write_we", VW'(bus.tbl_we), VW'(1));
    check("arb_write_addr", VW'(bus.tbl_waddr), VW'(33));
    wait_idle();

    // Fill the queue behind a stalled READ, then drain same-index updates
    bus.pred_req  = 1'b1;
    bus.pred_addr = AW'(3);
    for (int k = 0; k < 4; k++) send_req(9, '1, 1'b1, 0, 0);
    bus.trn_valid = 1'b1;
    #1;
    check("full_not_ready", VW'(bus.trn_ready), VW'(0));
    bus.trn_valid = 1'b0;
    bus.pred_req  = 1'b0;
    wait_idle();
    check("chain_bias", VW'(tbl_mem[9][W-1:0]), VW'(4));
    check("chain_table", tbl_mem[9], pack(9));

    // Reset in the middle of queued work
    bus.pred_req = 1'b1;
    for (int k = 0; k < 3; k++) send_req(9, '1, 1'b1, 0, 0);
    reset_and_sweep();
    wait_idle();
    check("flush_table", tbl_mem[9], pack(9));
    check("flush_cnt", VW'(train_cnt), VW'(0));

    // Randomized traffic over a small index set
    preload(0, 126);
    preload(1, -127);
    for (int r = 0; r < 80; r++) begin
      idx   = $urandom_range(0, 7);
      hist  = $urandom;
      taken = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       y = int'($urandom_range(0, 160)) - 80;
        1:       y = int'($urandom_range(0, 32767)) - 16384;
        2:       y = -16384;
        default: y = ($urandom_range(0, 1) != 0) ? (75 + int'($urandom_range(0, 1)))
                                                 : -(75 + int'($urandom_range(0, 1)));
      endcase
      send_req(idx, hist, taken, y, 1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    bus.pred_req = 1'b0;
    wait_idle();
    check("rand_queue_drained", VW'(exp_q.size()), VW'(0));
    check("rand_train_cnt", VW'(train_cnt), VW'(exp_train));
    check("rand_skip_cnt", VW'(skip_cnt), VW'(exp_skip));
    for (int p = 0; p < 8; p++) check("rand_table", tbl_mem[p], pack(p));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
